irq_sequencer: RTL and testbench

//  CPU-side consumer of the interrupt controller's irq_assert line.
//  - Samples irq_assert at instruction boundaries while interrupts are enabled.
//  - On entry: saves the return PC, flags and IE state on a small shadow stack, then redirects the core to a fixed vector.
//  - On RTI: pops the stack and restores PC, flags and IE.
//  - Sits between the interrupt controller and the core's fetch/flags logic.
//

---
 rtl/irq_sequencer.sv | 224 ++++++++++++++++++++++
 tb/tb_irq_sequencer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_sequencer.sv
// irq_sequencer: CPU-side interrupt entry/return sequencer.
// Samples irq_assert at instruction boundaries while interrupts are enabled.
// On entry it saves {return PC, flags, IE} and redirects fetch to VECTOR.
// On RTI it restores the saved PC, flags and IE.
// Optional feature macro: IRQ_SEQ_NEST_EN.
//   Defined:   nested interrupts, shadow stack of DEPTH entries.
//   Undefined: a single saved context, and a handler can never be interrupted.
module irq_sequencer #(
  parameter int              PC_W   = 16,
  parameter int              FLAG_W = 4,
  parameter int              DEPTH  = 4,
  parameter logic [PC_W-1:0] VECTOR = PC_W'(16'h0004)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              irq_assert,
  input  logic              insn_boundary,
  input  logic [PC_W-1:0]   cur_pc,
  input  logic [FLAG_W-1:0] cur_flags,
  input  logic              ie_set,
  input  logic              ie_clr,
  input  logic              rti,
  output logic              stall,
  output logic              redirect_valid,
  output logic [PC_W-1:0]   redirect_pc,
  output logic              flags_load,
  output logic [FLAG_W-1:0] flags_out,
  output logic              ie,
  output logic [2:0]        depth,
  output logic              rti_underflow
);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_ENTER,
    ST_RETURN
  } state_t;

  state_t state;
  state_t state_next;

  logic              take_rti;
  logic              take_irq;
  logic              hit_underflow;
  logic              ie_set_ok;
  logic              ie_next;
  logic [2:0]        depth_next;

  // Context on top of the save area (the one an RTI would restore).
  logic [PC_W-1:0]   top_pc;
  logic [FLAG_W-1:0] top_flags;
  logic              top_ie;

  // Context latched at the RTI decision and presented during RETURN.
  logic [PC_W-1:0]   ret_pc;
  logic [FLAG_W-1:0] ret_flags;
  logic              ret_ie;

`ifdef IRQ_SEQ_NEST_EN
  localparam int CAP   = DEPTH;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PC_W-1:0]   stk_pc    [DEPTH];
  logic [FLAG_W-1:0] stk_flags [DEPTH];
  logic              stk_ie    [DEPTH];
  logic [IDX_W-1:0]  push_idx;
  logic [IDX_W-1:0]  pop_idx;

  assign push_idx  = IDX_W'(depth);
  assign pop_idx   = IDX_W'(depth - 3'd1);
  assign ie_set_ok = 1'b1;

  // Shadow stack storage; entries are written on every accepted entry.
  always_ff @(posedge clk) begin
    if (take_irq) begin
      stk_pc[push_idx]    <= cur_pc;
      stk_flags[push_idx] <= cur_flags;
      stk_ie[push_idx]    <= ie;
    end
  end

  // The top of stack sits one below the current occupancy.
  always_comb begin
    top_pc    = stk_pc[pop_idx];
    top_flags = stk_flags[pop_idx];
    top_ie    = stk_ie[pop_idx];
  end
`else
  // One saved context only; DEPTH has no effect in this build.
  localparam int CAP = (DEPTH > 0) ? 1 : 1;

  logic [PC_W-1:0]   saved_pc;
  logic [FLAG_W-1:0] saved_flags;
  logic              saved_ie;

  // EI inside the handler is ignored so the handler cannot be interrupted.
  assign ie_set_ok = (depth == 3'd0);

  // Single saved-context register, loaded on entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      saved_pc    <= '0;
      saved_flags <= '0;
      saved_ie    <= 1'b0;
    end else if (take_irq) begin
      saved_pc    <= cur_pc;
      saved_flags <= cur_flags;
      saved_ie    <= ie;
    end
  end

  // The only entry is always the top.
  always_comb begin
    top_pc    = saved_pc;
    top_flags = saved_flags;
    top_ie    = saved_ie;
  end
`endif

  localparam logic [2:0] CAP_D = 3'(CAP);

  // Boundary decisions in RUN; RTI outranks a pending interrupt.
  always_comb begin
    take_rti      = 1'b0;
    hit_underflow = 1'b0;
    take_irq      = 1'b0;
    if (state == ST_RUN && insn_boundary) begin
      if (rti) begin
        take_rti      = (depth != 3'd0);
        hit_underflow = (depth == 3'd0);
      end else begin
        take_irq = irq_assert && ie && (depth < CAP_D);
      end
    end
  end

  // Next state and the redirect/flags outputs, decoded from the state.
  always_comb begin
    state_next     = state;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    flags_load     = 1'b0;
    flags_out      = '0;
    case (state)
      ST_RUN: begin
        if (take_rti) begin
          state_next = ST_RETURN;
        end else if (take_irq) begin
          state_next = ST_ENTER;
        end
      end
      ST_ENTER: begin
        stall          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = VECTOR;
        state_next     = ST_RUN;
      end
      ST_RETURN: begin
        stall          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = ret_pc;
        flags_load     = 1'b1;
        flags_out      = ret_flags;
        state_next     = ST_RUN;
      end
      default: begin
        state_next = ST_RUN;
      end
    endcase
  end

  // Interrupt-enable and occupancy updates; EI/DI only matter while running.
  always_comb begin
    ie_next    = ie;
    depth_next = depth;
    case (state)
      ST_RUN: begin
        if (take_irq) begin
          ie_next    = 1'b0;
          depth_next = depth + 3'd1;
        end else if (ie_clr) begin
          ie_next = 1'b0;
        end else if (ie_set && ie_set_ok) begin
          ie_next = 1'b1;
        end
      end
      ST_RETURN: begin
        ie_next    = ret_ie;
        depth_next = depth - 3'd1;
      end
      default: begin
        ie_next    = ie;
        depth_next = depth;
      end
    endcase
  end

  // State, enable, occupancy, sticky underflow and the latched return context.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_RUN;
      ie            <= 1'b0;
      depth         <= 3'd0;
      rti_underflow <= 1'b0;
      ret_pc        <= '0;
      ret_flags     <= '0;
      ret_ie        <= 1'b0;
    end else begin
      state <= state_next;
      ie    <= ie_next;
      depth <= depth_next;
      if (hit_underflow) begin
        rti_underflow <= 1'b1;
      end
      if (take_rti) begin
        ret_pc    <= top_pc;
        ret_flags <= top_flags;
        ret_ie    <= top_ie;
      end
    end
  end

endmodule

// File: tb/tb_irq_sequencer.sv
// tb_irq_sequencer: self-checking bench for irq_sequencer.
// A queue-based reference model predicts every output each cycle;
// directed scenarios add literal expectations, then random traffic follows.
// Honours IRQ_SEQ_NEST_EN the same way as the design.
module tb_irq_sequencer;

  localparam logic [15:0] VEC = 16'h0004;
`ifdef IRQ_SEQ_NEST_EN
  localparam int CAP = 4;
`else
  localparam int CAP = 1;
`endif

  logic        clk;
  logic        reset_n;
  logic        irq_assert;
  logic        insn_boundary;
  logic [15:0] cur_pc;
  logic [3:0]  cur_flags;
  logic        ie_set;
  logic        ie_clr;
  logic        rti;
  logic        stall;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        flags_load;
  logic [3:0]  flags_out;
  logic        ie;
  logic [2:0]  depth;
  logic        rti_underflow;

  irq_sequencer #(
    .PC_W  (16),
    .FLAG_W(4),
    .DEPTH (4),
    .VECTOR(VEC)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .irq_assert    (irq_assert),
    .insn_boundary (insn_boundary),
    .cur_pc        (cur_pc),
    .cur_flags     (cur_flags),
    .ie_set        (ie_set),
    .ie_clr        (ie_clr),
    .rti           (rti),
    .stall         (stall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .flags_load    (flags_load),
    .flags_out     (flags_out),
    .ie            (ie),
    .depth         (depth),
    .rti_underflow (rti_underflow)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] pc;
    logic [3:0]  fl;
    logic        ie;
  } ctx_t;

  // Reference model: saved contexts, enable, sticky flag, pending redirect.
  ctx_t        mStack[$];
  logic        mIe;
  logic        mUf;
  int          mPend;
  ctx_t        mRet;

  int checks;
  int failures;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    mStack.delete();
    mIe   = 1'b0;
    mUf   = 1'b0;
    mPend = 0;
    mRet  = '{pc: 16'h0, fl: 4'h0, ie: 1'b0};
  endtask

  task automatic modelEiDi();
    if (ie_clr) mIe = 1'b0;
    else if (ie_set && (CAP > 1 || mStack.size() == 0)) mIe = 1'b1;
  endtask

  // One clock edge of the model, using the inputs held across that edge.
  task automatic modelUpdate();
    ctx_t c;
    if (mPend == 2) begin
      mIe = mRet.ie;
      void'(mStack.pop_back());
      mPend = 0;
    end else if (mPend == 1) begin
      mPend = 0;
    end else if (insn_boundary && rti) begin
      if (mStack.size() > 0) begin
        mRet  = mStack[mStack.size()-1];
        mPend = 2;
      end else begin
        mUf = 1'b1;
      end
      modelEiDi();
    end else if (insn_boundary && irq_assert && mIe && mStack.size() < CAP) begin
      c.pc = cur_pc;
      c.fl = cur_flags;
      c.ie = mIe;
      mStack.push_back(c);
      mIe   = 1'b0;
      mPend = 1;
    end else begin
      modelEiDi();
    end
  endtask

  // Compare every DUT output with the model.
  task automatic checkOutput();
    logic [15:0] eRpc;
    eRpc = (mPend == 1) ? VEC : (mPend == 2) ? mRet.pc : 16'h0;
    chk("stall", 32'(stall), 32'(mPend != 0));
    chk("redirect_valid", 32'(redirect_valid), 32'(mPend != 0));
    chk("redirect_pc", 32'(redirect_pc), 32'(eRpc));
    chk("flags_load", 32'(flags_load), 32'(mPend == 2));
    chk("flags_out", 32'(flags_out), (mPend == 2) ? 32'(mRet.fl) : 32'h0);
    chk("ie", 32'(ie), 32'(mIe));
    chk("depth", 32'(depth), 32'(mStack.size()));
    chk("rti_underflow", 32'(rti_underflow), 32'(mUf));
  endtask

  // Drive one cycle of inputs, step the model on the edge, check at negedge.
  task automatic applyStimulus(input logic bnd, input logic irq, input logic r,
                               input logic es, input logic ec,
                               input logic [15:0] pc, input logic [3:0] fl);
    insn_boundary = bnd;
    irq_assert    = irq;
    rti           = r;
    ie_set        = es;
    ie_clr        = ec;
    cur_pc        = pc;
    cur_flags     = fl;
    @(posedge clk);
    modelUpdate();
    @(negedge clk);
    checkOutput();
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 4'h0);
  endtask

  // Directed scenarios followed by randomized traffic.
  initial begin
    checks        = 0;
    failures      = 0;
    reset_n       = 1'b0;
    irq_assert    = 1'b0;
    insn_boundary = 1'b0;
    cur_pc        = 16'h0;
    cur_flags     = 4'h0;
    ie_set        = 1'b0;
    ie_clr        = 1'b0;
    rti           = 1'b0;
    modelReset();
    repeat (2) @(negedge clk);
    chk("reset_ie", 32'(ie), 32'h0);
    chk("reset_depth", 32'(depth), 32'h0);
    chk("reset_stall", 32'(stall), 32'h0);
    chk("reset_rv", 32'(redirect_valid), 32'h0);
    chk("reset_uf", 32'(rti_underflow), 32'h0);
    reset_n = 1'b1;
    checkOutput();

    // Entry from PC 0x0120 with flags 0xA.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 4'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0120, 4'hA);
    chk("entry_rv", 32'(redirect_valid), 32'h1);
    chk("entry_pc", 32'(redirect_pc), 32'h0004);
    chk("entry_stall", 32'(stall), 32'h1);
    chk("entry_depth", 32'(depth), 32'h1);
    chk("entry_ie", 32'(ie), 32'h0);
    idle();

    // Return restores PC, flags and IE.
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 4'h0);
    chk("ret_pc", 32'(redirect_pc), 32'h0120);
    chk("ret_fload", 32'(flags_load), 32'h1);
    chk("ret_flags", 32'(flags_out), 32'hA);
    idle();
    chk("ret_ie", 32'(ie), 32'h1);
    chk("ret_depth", 32'(depth), 32'h0);

    // RTI and irq together: return first, entry on the next boundary.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0200, 4'h3);
    idle();
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0210, 4'h0);
    chk("prio_fload", 32'(flags_load), 32'h1);
    chk("prio_pc", 32'(redirect_pc), 32'h0200);
    idle();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0210, 4'h5);
    chk("prio_entry_pc", 32'(redirect_pc), 32'h0004);
    chk("prio_entry_fl", 32'(flags_load), 32'h0);
    idle();
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 4'h0);
    idle();

    // EI and DI together: clear wins.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0, 4'h0);
    chk("eidi_ie", 32'(ie), 32'h0);

    // RTI with nothing saved.
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 4'h0);
    chk("uf_flag", 32'(rti_underflow), 32'h1);
    chk("uf_rv", 32'(redirect_valid), 32'h0);
    idle();
    chk("uf_sticky", 32'(rti_underflow), 32'h1);

`ifdef IRQ_SEQ_NEST_EN
    // Nest four deep, fifth is held off, then unwind in LIFO order.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 4'h0);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0100 + 16'(i), 4'(i));
      idle();
    end
    chk("nest_depth", 32'(depth), 32'h4);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 4'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0200, 4'h0);
    chk("nest_full_rv", 32'(redirect_valid), 32'h0);
    chk("nest_full_depth", 32'(depth), 32'h4);
    for (int i = 3; i >= 0; i--) begin
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 4'h0);
      chk("nest_unwind_pc", 32'(redirect_pc), 32'h0100 + 32'(i));
      chk("nest_unwind_fl", 32'(flags_out), 32'(i));
      idle();
    end
    chk("nest_end_depth", 32'(depth), 32'h0);
    chk("nest_end_ie", 32'(ie), 32'h1);
`else
    // EI inside the only handler level is ignored.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 4'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0100, 4'h1);
    idle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 4'h0);
    chk("single_ei_ignored", 32'(ie), 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0300, 4'h0);
    chk("single_held_off", 32'(redirect_valid), 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 4'h0);
    chk("single_ret_pc", 32'(redirect_pc), 32'h0100);
    idle();
`endif

    // Reset asserted in the middle of ENTER clears outputs immediately.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 4'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0300, 4'h5);
    chk("pre_reset_rv", 32'(redirect_valid), 32'h1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rv", 32'(redirect_valid), 32'h0);
    chk("async_stall", 32'(stall), 32'h0);
    chk("async_pc", 32'(redirect_pc), 32'h0);
    chk("async_depth", 32'(depth), 32'h0);
    chk("async_ie", 32'(ie), 32'h0);
    chk("async_uf", 32'(rti_underflow), 32'h0);
    modelReset();
    @(negedge clk);
    reset_n = 1'b1;
    checkOutput();

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      applyStimulus(($urandom_range(0, 2) != 0),
                    ($urandom_range(0, 9) < 6),
                    ($urandom_range(0, 6) == 0),
                    ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 15) == 0),
                    16'($urandom()), 4'($urandom()));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
